vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 129 ++++++++++++
 tb/tb_vga_sync_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator.
// Free-running pixel/line counters advanced by a pixel-clock enable, with
// sync and visible-area flags decoded combinationally from the counters so
// that anything indexed by hpos/vpos lines up in the same cycle.
// Optional build macro: VGA_FRAME_COUNTER_EN adds an 8-bit frame_count output
// that increments on every frame_end and wraps 255 -> 0.
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
`ifdef VGA_FRAME_COUNTER_EN
    output logic [7:0] frame_count,
`endif
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_end,
    output logic       frame_end
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS_END  = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [9:0] hpos_r;
    logic [9:0] vpos_r;
    logic [9:0] hpos_nxt_s;
    logic [9:0] vpos_nxt_s;
    logic       h_last_s;
    logic       v_last_s;
    logic       line_end_s;
    logic       frame_end_s;
    logic       hsync_s;
    logic       vsync_s;
    logic       display_on_s;

    // End-of-line / end-of-frame detection; >= so a corrupted counter still wraps.
    always_comb begin
        h_last_s    = (hpos_r >= H_LAST);
        v_last_s    = (vpos_r >= V_LAST);
        line_end_s  = ce & (hpos_r == H_LAST);
        frame_end_s = line_end_s & (vpos_r == V_LAST);
    end

    // Next raster position: advance only on enabled cycles, wrap at totals.
    always_comb begin
        hpos_nxt_s = hpos_r;
        vpos_nxt_s = vpos_r;
        if (ce) begin
            if (h_last_s) begin
                hpos_nxt_s = 10'd0;
                if (v_last_s) begin
                    vpos_nxt_s = 10'd0;
                end else begin
                    vpos_nxt_s = vpos_r + 10'd1;
                end
            end else begin
                hpos_nxt_s = hpos_r + 10'd1;
                vpos_nxt_s = vpos_r;
            end
        end else begin
            hpos_nxt_s = hpos_r;
            vpos_nxt_s = vpos_r;
        end
    end

    // Raster position registers; reset wins over ce and restarts at (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_r <= 10'd0;
            vpos_r <= 10'd0;
        end else begin
            hpos_r <= hpos_nxt_s;
            vpos_r <= vpos_nxt_s;
        end
    end

    // Zero-latency sync and visible-area decode from the registered position.
    always_comb begin
        hsync_s      = ~((hpos_r >= HS_START) && (hpos_r < HS_END));
        vsync_s      = ~((vpos_r >= VS_START) && (vpos_r < VS_END));
        display_on_s = (hpos_r < H_VIS_END) && (vpos_r < V_VIS_END);
    end

`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] frame_count_r;

    // Frame counter: one step per completed frame, natural 8-bit wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_r <= 8'd0;
        end else if (frame_end_s) begin
            frame_count_r <= frame_count_r + 8'd1;
        end else begin
            frame_count_r <= frame_count_r;
        end
    end

    assign frame_count = frame_count_r;
`endif

    assign hpos       = hpos_r;
    assign vpos       = vpos_r;
    assign hsync      = hsync_s;
    assign vsync      = vsync_s;
    assign display_on = display_on_s;
    assign line_end   = line_end_s;
    assign frame_end  = frame_end_s;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for vga_sync_gen.
// Two instances share clk/reset/ce: one with default 640x480 timing (line
// level behaviour) and one with a tiny raster so whole frames, display-area
// corners and frame-counter wrap fit in a short run.
// The reference model tracks a single linear pixel index per instance and
// derives position and flags with division/modulo from the timing numbers.
module tb_vga_sync_gen;

    localparam int SH_D = 8, SH_F = 2, SH_S = 3, SH_B = 2;
    localparam int SV_D = 6, SV_F = 1, SV_S = 2, SV_B = 2;
    localparam int SHT  = SH_D + SH_F + SH_S + SH_B;
    localparam int SVT  = SV_D + SV_F + SV_S + SV_B;
    localparam int BH_D = 640, BH_F = 16, BH_S = 96, BH_B = 48;
    localparam int BV_D = 480, BV_F = 10, BV_S = 2,  BV_B = 33;
    localparam int BHT  = BH_D + BH_F + BH_S + BH_B;
    localparam int BVT  = BV_D + BV_F + BV_S + BV_B;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic       le;
        logic       fe;
        logic [7:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    logic ce;

    logic [9:0] s_hpos, s_vpos, b_hpos, b_vpos;
    logic       s_hsync, s_vsync, s_de, s_le, s_fe;
    logic       b_hsync, b_vsync, b_de, b_le, b_fe;
`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] s_fc, b_fc;
`endif

    int checks   = 0;
    int failures = 0;

    obs_t sq[$];
    obs_t bq[$];

    int sp = 0, sfc = 0, bp = 0, bfc = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_DISPLAY(SH_D), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_DISPLAY(SV_D), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B)
    ) dut_small (
        .clk(clk), .reset(reset), .ce(ce),
`ifdef VGA_FRAME_COUNTER_EN
        .frame_count(s_fc),
`endif
        .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hsync), .vsync(s_vsync),
        .display_on(s_de), .line_end(s_le), .frame_end(s_fe)
    );

    vga_sync_gen dut_big (
        .clk(clk), .reset(reset), .ce(ce),
`ifdef VGA_FRAME_COUNTER_EN
        .frame_count(b_fc),
`endif
        .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hsync), .vsync(b_vsync),
        .display_on(b_de), .line_end(b_le), .frame_end(b_fe)
    );

    // Expected observation for linear pixel index p under given timing.
    function automatic obs_t model(int p, int fc, logic ce_v,
                                   int hd, int hf, int hs, int ht,
                                   int vd, int vf, int vs, int vt);
        obs_t e;
        int h, v;
        h    = p % ht;
        v    = p / ht;
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.hs = !((h >= hd + hf) && (h < hd + hf + hs));
        e.vs = !((v >= vd + vf) && (v < vd + vf + vs));
        e.de = (h < hd) && (v < vd);
        e.le = ce_v && (h == ht - 1);
        e.fe = e.le && (v == vt - 1);
`ifdef VGA_FRAME_COUNTER_EN
        e.fc = 8'(fc);
`else
        e.fc = 8'd0;
`endif
        return e;
    endfunction

    // One cycle of stimulus: drive inputs, queue expectations, advance model.
    task automatic step(input logic r, input logic c);
        @(negedge clk);
        #1;
        reset = r;
        ce    = c;
        sq.push_back(model(sp, sfc, c, SH_D, SH_F, SH_S, SHT, SV_D, SV_F, SV_S, SVT));
        bq.push_back(model(bp, bfc, c, BH_D, BH_F, BH_S, BHT, BV_D, BV_F, BV_S, BVT));
        if (r) begin
            sp = 0; sfc = 0; bp = 0; bfc = 0;
        end else if (c) begin
            if (sp == SHT * SVT - 1) sfc = (sfc + 1) % 256;
            sp = (sp + 1) % (SHT * SVT);
            if (bp == BHT * BVT - 1) bfc = (bfc + 1) % 256;
            bp = (bp + 1) % (BHT * BVT);
        end
    endtask

    // Monitor: whenever expectations are pending, sample both DUTs and compare.
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            #3;
            if (sq.size() > 0) begin
                e = sq.pop_front();
                a = '{h: s_hpos, v: s_vpos, hs: s_hsync, vs: s_vsync, de: s_de,
                      le: s_le, fe: s_fe, fc: 8'd0};
`ifdef VGA_FRAME_COUNTER_EN
                a.fc = s_fc;
`endif
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL small_dut t=%0t actual=%h required=%h (req h=%0d v=%0d fc=%0d)",
                             $time, a, e, e.h, e.v, e.fc);
                end
            end
            if (bq.size() > 0) begin
                e = bq.pop_front();
                a = '{h: b_hpos, v: b_vpos, hs: b_hsync, vs: b_vsync, de: b_de,
                      le: b_le, fe: b_fe, fc: 8'd0};
`ifdef VGA_FRAME_COUNTER_EN
                a.fc = b_fc;
`endif
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL big_dut t=%0t actual=%h required=%h (req h=%0d v=%0d)",
                             $time, a, e, e.h, e.v);
                end
            end
        end
    end

    // Stimulus: directed line/toggle/reset phases, random ce, then long frame run.
    initial begin
        reset = 1'b1;
        ce    = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held (both with and without ce), then a full default line.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < BHT + 4; i++) step(1'b0, 1'b1);

        // ce toggling 1,0,1,0: position advances every other cycle.
        for (int i = 0; i < 400; i++) step(1'b0, (i % 2) == 0);

        // Random ce with occasional mid-frame resets.
        for (int i = 0; i < 20000; i++) begin
            logic r, c;
            r = ($urandom_range(0, 2999) == 0) || (i == 5000) || (i == 12345);
            c = ($urandom_range(0, 3) != 0);
            step(r, c);
        end

        // Continuous ce from reset: many small frames, frame-counter wrap.
        step(1'b1, 1'b1);
        for (int i = 0; i < 256 * SHT * SVT + 5; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #5;
        checks++;
        if (sq.size() != 0 || bq.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d/%0d pending required=0/0", sq.size(), bq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
